// File: rtl/spi_target_pkg.sv
// Shared definitions for the SPI target: FSM encoding, bit-counter width and
// the default fill byte sent when nothing is queued for transmit.
package spi_target_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2
  } state_e;

  localparam int         BIT_CNT_W         = 3;
  localparam logic [7:0] IDLE_FILL_DEFAULT = 8'hFF;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous input, with single-cycle
// rise/fall pulses derived from one extra registered copy.
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  // Synchroniser chain plus the delayed copy used for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= {SYNC_STAGES{RESET_VAL}};
      r_prev <= RESET_VAL;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_level = r_sync[SYNC_STAGES-1];
  assign o_rise  = r_sync[SYNC_STAGES-1] & ~r_prev;
  assign o_fall  = ~r_sync[SYNC_STAGES-1] & r_prev;

endmodule

// File: rtl/spi_target.sv
// Mode-0 SPI target, oversampled by clk: byte-wide RX/TX valid-ready streams
// with a single TX holding register and sticky overrun/underrun flags.
module spi_target
  import spi_target_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] IDLE_FILL   = IDLE_FILL_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       spi_sck,
  input  logic       spi_cs_n,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       overrun,
  output logic       underrun,
  input  logic       err_clr,
  output logic       busy
);

  state_e                 r_state;
  state_e                 w_state_nxt;
  logic [BIT_CNT_W-1:0]   r_bit_cnt;
  logic [6:0]             r_rx_shift;
  logic [7:0]             r_rx_data;
  logic                   r_rx_valid;
  logic [7:0]             r_tx_shift;
  logic [7:0]             r_tx_hold;
  logic                   r_tx_full;
  logic                   r_reload_pend;
  logic                   r_overrun;
  logic                   r_underrun;

  logic w_sck_level, w_sck_rise, w_sck_fall;
  logic w_cs_level, w_cs_rise, w_cs_fall;
  logic w_mosi_level, w_mosi_rise, w_mosi_fall;
  logic w_unused;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
    .clk(clk), .rst_n(rst_n), .i_async(spi_sck),
    .o_level(w_sck_level), .o_rise(w_sck_rise), .o_fall(w_sck_fall)
  );
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst_n(rst_n), .i_async(spi_cs_n),
    .o_level(w_cs_level), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
  );
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst_n(rst_n), .i_async(spi_mosi),
    .o_level(w_mosi_level), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall)
  );

  assign w_unused = w_sck_level ^ w_mosi_rise ^ w_mosi_fall;

  // A cs_n rise in the same cycle as an SCK edge wins: the edge is dropped.
  logic       w_in_shift, w_bit_rise, w_byte_done, w_reload, w_tx_accept, w_rx_take;
  logic [7:0] w_rx_byte;

  assign w_in_shift  = (r_state == ST_SHIFT) & ~w_cs_rise;
  assign w_bit_rise  = w_in_shift & w_sck_rise;
  assign w_byte_done = w_bit_rise & (r_bit_cnt == 3'd7);
  assign w_reload    = ((r_state == ST_LOAD) & ~w_cs_rise) |
                       (w_in_shift & w_sck_fall & r_reload_pend);
  assign w_tx_accept = tx_valid & ~r_tx_full;
  assign w_rx_take   = r_rx_valid & rx_ready;
  assign w_rx_byte   = {r_rx_shift, w_mosi_level};

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM next-state
  always_comb begin
    w_state_nxt = r_state;
    if (w_cs_rise) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  w_state_nxt = w_cs_fall ? ST_LOAD : ST_IDLE;
        ST_LOAD:  w_state_nxt = ST_SHIFT;
        ST_SHIFT: w_state_nxt = ST_SHIFT;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // RX shifter and bit counter; any exit from SHIFT drops partial bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_cnt  <= '0;
      r_rx_shift <= 7'd0;
    end else if (!w_in_shift) begin
      r_bit_cnt  <= '0;
      r_rx_shift <= 7'd0;
    end else if (w_bit_rise) begin
      r_bit_cnt  <= r_bit_cnt + BIT_CNT_W'(1);
      r_rx_shift <= w_rx_byte[6:0];
    end
  end

  // Arms a TX reload for the first falling edge after each completed byte
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           r_reload_pend <= 1'b0;
    else if (!w_in_shift) r_reload_pend <= 1'b0;
    else if (w_byte_done) r_reload_pend <= 1'b1;
    else if (w_reload)    r_reload_pend <= 1'b0;
  end

  // RX output register with valid/ready handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_data  <= 8'h00;
      r_rx_valid <= 1'b0;
    end else if (w_byte_done && (!r_rx_valid || w_rx_take)) begin
      r_rx_data  <= w_rx_byte;
      r_rx_valid <= 1'b1;
    end else if (w_rx_take) begin
      r_rx_valid <= 1'b0;
    end
  end

  // TX holding register and shifter; an accept coinciding with a reload bypasses holding
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_shift <= 8'h00;
      r_tx_hold  <= 8'h00;
      r_tx_full  <= 1'b0;
    end else if (w_reload) begin
      if (r_tx_full) begin
        r_tx_shift <= r_tx_hold;
        r_tx_full  <= 1'b0;
      end else if (tx_valid) begin
        r_tx_shift <= tx_data;
      end else begin
        r_tx_shift <= IDLE_FILL;
      end
    end else begin
      if (w_in_shift && w_sck_fall) r_tx_shift <= {r_tx_shift[6:0], 1'b0};
      if (w_tx_accept) begin
        r_tx_hold <= tx_data;
        r_tx_full <= 1'b1;
      end
    end
  end

  // Sticky error flags; a setting event beats err_clr
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overrun  <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      if (w_byte_done && r_rx_valid && !w_rx_take) r_overrun <= 1'b1;
      else if (err_clr)                             r_overrun <= 1'b0;
      if (w_reload && !r_tx_full && !tx_valid)      r_underrun <= 1'b1;
      else if (err_clr)                             r_underrun <= 1'b0;
    end
  end

  assign spi_miso    = r_tx_shift[7];
  assign busy        = ~w_cs_level;
  assign spi_miso_oe = ~w_cs_level;
  assign rx_data     = r_rx_data;
  assign rx_valid    = r_rx_valid;
  assign tx_ready    = ~r_tx_full;
  assign overrun     = r_overrun;
  assign underrun    = r_underrun;

endmodule

// File: doc/spi_target.md
SPI_TARGET -- requirements
Module: spi_target

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: synchroniser depth for sck, cs_n and mosi; legal values 2..3.
REQ-002 SHALL have parameter IDLE_FILL, default 8'hFF: byte shifted out when no TX byte is queued.
REQ-003 SHALL have port clk, input, 1: single clock; every flop is on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-005 SHALL have port spi_sck, input, 1: SPI clock from the initiator (VIA PA2 bit-bang), mode 0.
REQ-006 SHALL have port spi_cs_n, input, 1: chip select, active-low (PA0).
REQ-007 SHALL have port spi_mosi, input, 1: data from the initiator (PA1).
REQ-008 SHALL have port spi_miso, output, 1: data to the initiator (PA3).
REQ-009 SHALL have port spi_miso_oe, output, 1: MISO drive enable, high only while selected.
REQ-010 SHALL have port rx_data, output, 8: received byte.
REQ-011 SHALL have port rx_valid, output, 1: rx_data holds an unconsumed byte.
REQ-012 SHALL have port rx_ready, input, 1: consumer accepts rx_data when rx_valid and rx_ready are both high.
REQ-013 SHALL have port tx_data, input, 8: next byte to transmit.
REQ-014 SHALL have port tx_valid, input, 1: tx_data is offered.
REQ-015 SHALL have port tx_ready, output, 1: TX holding register is empty; a byte is accepted on tx_valid & tx_ready.
REQ-016 SHALL have port overrun, output, 1: sticky; a byte completed while rx_valid was high.
REQ-017 SHALL have port underrun, output, 1: sticky; IDLE_FILL was loaded because TX holding was empty.
REQ-018 SHALL have port err_clr, input, 1: synchronous clear of overrun and underrun.
REQ-019 SHALL have port busy, output, 1: high while synchronised cs_n is low.

Function
REQ-020 SHALL synchronise sck, cs_n and mosi through SYNC_STAGES flops, then detect edges by comparing against one more registered copy; the clk rate SHALL be at least 4x the SCK rate.
REQ-021 SHALL implement FSM IDLE -> LOAD -> SHIFT -> IDLE.
  - IDLE -> LOAD on a cs_n falling edge.
  - LOAD -> SHIFT after 1 cycle.
  - SHIFT -> IDLE on a cs_n rising edge, from any state.
REQ-022 In LOAD and on the first SCK falling edge after each completed byte, the TX shift register SHALL load from TX holding and set tx_ready=1.
  - If holding is empty, it SHALL load IDLE_FILL and set underrun.
REQ-023 spi_miso SHALL always present bit 7 of the TX shift register; spi_miso_oe=busy.
REQ-024 On each SCK rising edge in SHIFT, the block SHALL shift mosi into bit 0 of the RX shift register and increment the 3-bit bit counter.
  - The counter wraps 7 -> 0.
REQ-025 On each SCK falling edge in SHIFT, the TX shift register SHALL shift left, except on a reload edge (REQ-022).
REQ-026 On the 8th rising edge (counter 7 -> 0), the assembled byte SHALL be written to rx_data with rx_valid=1 in the following cycle.
  - If rx_valid is already 1 and not being consumed that cycle, the old byte is kept and overrun is set.
REQ-027 rx_valid SHALL clear in the cycle after an rx_valid & rx_ready handshake.
  - A simultaneous handshake and new completion SHALL deliver the new byte without setting overrun.
REQ-028 A cs_n rise mid-byte SHALL discard the partial RX bits and reset the bit counter without asserting rx_valid or overrun.
  - A TX byte already loaded SHALL be consumed.
REQ-029 SCK edges while in IDLE or LOAD SHALL be ignored.
REQ-030 tx_ready=0 SHALL take effect the cycle after a TX accept.
  - A simultaneous accept and reload SHALL pass the byte straight to the TX shift register and leave tx_ready=1.
REQ-031 err_clr SHALL clear the flags unless a setting event occurs in the same cycle, in which case set wins.

Reset
REQ-032 While rst_n=0, the block SHALL hold the following values:
  - FSM state = IDLE, bit counter = 0
  - rx_valid=0, rx_data=8'h00
  - tx_ready=1, TX holding empty
  - spi_miso=0, spi_miso_oe=0, busy=0
  - overrun=0, underrun=0
  - synchronisers = idle level (cs_n=1, sck=0, mosi=0)
REQ-033 After reset deasserts, the block SHALL require a fresh cs_n falling edge before shifting.
  - A transfer in progress when reset asserted SHALL be abandoned.

Structure
REQ-034 SHALL place the FSM state encodings, the bit-count width (3) and the default IDLE_FILL in a shared package.
REQ-035 SHALL use one sub-module, spi_sync_edge, per input: parameterised synchroniser plus rise/fall pulse outputs.

Verification
REQ-036 Reset check: hold tx_valid with tx_data=8'hA5, assert cs_n low, clock 8 SCK cycles with MOSI=8'h3C -> MISO bits 1,0,1,0,0,1,0,1; rx_data=8'h3C; rx_valid=1; underrun=0.
REQ-037 Empty-TX check: run a transfer with the TX holding register empty -> MISO returns 8'hFF and underrun=1; err_clr -> underrun=0.
REQ-038 Overrun check: send two bytes 8'h11 and 8'h22 with rx_ready=0 -> rx_data=8'h11 and overrun=1; then rx_ready=1 -> rx_valid=0.
REQ-039 Partial-byte check: raise cs_n after 5 SCK cycles, then send a full byte 8'h81 -> rx_data=8'h81 only; no overrun.
REQ-040 Back-to-back check: send 3 bytes without a cs_n gap, refilling TX after each tx_ready -> all 3 bytes correct in both directions.
REQ-041 Reset-abort check: assert rst_n low mid-byte -> all outputs at reset values within 1 clk; the next full transfer is correct.
